// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------------------------
// mem_stage_ctrl
//
// Consumer end of the EX/MEM pipeline register. Issues data-cache requests for loads and
// stores, stalls EX/MEM and every earlier stage while an access is outstanding, and owns the
// MEM/WB latch so writeback only ever sees registered, bubble-clean results.
//
// A misaligned access (odd address, or read and write together) is dropped and raises a
// sticky err_align. An access that waits TIMEOUT cycles without dmem_done is aborted and
// raises a sticky err_timeout. HALT parks the block in a halted state that only reset leaves.
//
// Parameters
//   TIMEOUT                   stall cycles allowed before a pending access is aborted (>= 2)
//
// Ports
//   clk                       clock
//   rst                       synchronous reset, active low
//   alu_result_syn_EXMEM      memory address / ALU result
//   Read_rg_data_2_syn_EXMEM  store data
//   PC_2_JAL_syn_EXMEM        link value written back for JAL
//   MemRead/MemWrite/MemReg/RegWrite/JAL/HALT _syn_EXMEM   EX/MEM control bits
//   RegWrite_addr_syn_EXMEM   destination register
//   dmem_rdata, dmem_done     cache read data and completion (may arrive in the request cycle)
//   dmem_addr, dmem_wdata     cache address and write data
//   dmem_rd, dmem_wr          cache request strobes (combinational)
//   mem_stall                 freeze upstream; EX/MEM enable = ~mem_stall (combinational)
//   wb_data/wb_addr/wb_regwrite/wb_halt   registered MEM/WB outputs
//   err_align, err_timeout    sticky error flags
// ---------------------------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_result_syn_EXMEM,
    input  logic [15:0] Read_rg_data_2_syn_EXMEM,
    input  logic [15:0] PC_2_JAL_syn_EXMEM,
    input  logic        MemRead_syn_EXMEM,
    input  logic        MemWrite_syn_EXMEM,
    input  logic        MemReg_syn_EXMEM,
    input  logic        RegWrite_syn_EXMEM,
    input  logic        JAL_syn_EXMEM,
    input  logic        HALT_syn_EXMEM,
    input  logic [2:0]  RegWrite_addr_syn_EXMEM,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_done,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        mem_stall,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_addr,
    output logic        wb_regwrite,
    output logic        wb_halt,
    output logic        err_align,
    output logic        err_timeout
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntTop = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Request captured at issue; replayed verbatim on every BUSY cycle.
    logic              req_rd_q, req_rd_d;
    logic              req_wr_q, req_wr_d;
    logic [15:0]       req_addr_q, req_addr_d;
    logic [15:0]       req_wdata_q, req_wdata_d;

    logic [15:0]       wb_data_q, wb_data_d;
    logic [2:0]        wb_addr_q, wb_addr_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              wb_halt_q, wb_halt_d;
    logic              err_align_q, err_align_d;
    logic              err_timeout_q, err_timeout_d;

    logic              mem_op;
    logic              misaligned;
    logic              release_now;
    logic              align_fault;
    logic              timeout_fault;
    logic              halt_now;
    logic [15:0]       wb_sel_data;

    assign mem_op     = MemRead_syn_EXMEM | MemWrite_syn_EXMEM;
    // Read and write together is treated like an odd address: undefined, so dropped.
    assign misaligned = alu_result_syn_EXMEM[0] | (MemRead_syn_EXMEM & MemWrite_syn_EXMEM);

    assign wb_sel_data = JAL_syn_EXMEM    ? PC_2_JAL_syn_EXMEM :
                         MemReg_syn_EXMEM ? dmem_rdata         :
                                            alu_result_syn_EXMEM;

    // -----------------------------------------------------------------------------------------
    // Request / stall decode and FSM next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_rd_d      = req_rd_q;
        req_wr_d      = req_wr_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;

        dmem_rd       = 1'b0;
        dmem_wr       = 1'b0;
        dmem_addr     = alu_result_syn_EXMEM;
        dmem_wdata    = Read_rg_data_2_syn_EXMEM;
        mem_stall     = 1'b0;

        release_now   = 1'b0;
        align_fault   = 1'b0;
        timeout_fault = 1'b0;
        halt_now      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (mem_op && !misaligned) begin
                    dmem_rd     = MemRead_syn_EXMEM;
                    dmem_wr     = MemWrite_syn_EXMEM;
                    req_rd_d    = MemRead_syn_EXMEM;
                    req_wr_d    = MemWrite_syn_EXMEM;
                    req_addr_d  = alu_result_syn_EXMEM;
                    req_wdata_d = Read_rg_data_2_syn_EXMEM;
                    if (dmem_done) begin
                        // Zero-latency hit: no stall cycle at all.
                        release_now = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = StBusy;
                    end
                end else if (mem_op) begin
                    release_now = 1'b1;
                    align_fault = 1'b1;
                end else begin
                    release_now = 1'b1;
                    if (HALT_syn_EXMEM) begin
                        halt_now = 1'b1;
                        state_d  = StHalted;
                    end
                end
            end

            StBusy: begin
                dmem_rd    = req_rd_q;
                dmem_wr    = req_wr_q;
                dmem_addr  = req_addr_q;
                dmem_wdata = req_wdata_q;
                if (dmem_done) begin
                    release_now = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                end else if (cnt_q == CntTop) begin
                    // Abort: strobes fall in this same cycle and the instruction retires dead.
                    dmem_rd       = 1'b0;
                    dmem_wr       = 1'b0;
                    release_now   = 1'b1;
                    timeout_fault = 1'b1;
                    state_d       = StIdle;
                    cnt_d         = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end

            StHalted: begin
                cnt_d = '0;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // MEM/WB latch and sticky errors
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wb_data_d     = wb_data_q;
        wb_addr_d     = wb_addr_q;
        wb_regwrite_d = 1'b0;
        wb_halt_d     = 1'b0;
        err_align_d   = err_align_q | align_fault;
        err_timeout_d = err_timeout_q | timeout_fault;

        if (state_q == StHalted) begin
            // Retired HALT: keep signalling halt, never write the register file again.
            wb_halt_d = 1'b1;
        end else if (release_now) begin
            wb_data_d     = wb_sel_data;
            wb_addr_d     = RegWrite_addr_syn_EXMEM;
            wb_regwrite_d = RegWrite_syn_EXMEM & ~align_fault & ~timeout_fault;
            wb_halt_d     = halt_now;
        end
        // Stall cycle: the defaults above insert a bubble and hold data/address.
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_rd_q      <= 1'b0;
            req_wr_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_regwrite_q <= 1'b0;
            wb_halt_q     <= 1'b0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_rd_q      <= req_rd_d;
            req_wr_q      <= req_wr_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            wb_data_q     <= wb_data_d;
            wb_addr_q     <= wb_addr_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_halt_q     <= wb_halt_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_halt     = wb_halt_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed bench for mem_stage_ctrl. A table of per-cycle EX/MEM + cache inputs with the
// expected combinational outputs (mid-cycle) and registered outputs (after the edge), followed
// by a hand-written cache-timeout sequence.
// ---------------------------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    // Control bit positions: {rst_n, MemRead, MemWrite, MemReg, RegWrite, JAL, HALT}
    localparam logic [6:0] CRun  = 7'b1000000;
    localparam logic [6:0] CRd   = 7'b0100000;
    localparam logic [6:0] CWr   = 7'b0010000;
    localparam logic [6:0] CMreg = 7'b0001000;
    localparam logic [6:0] CRw   = 7'b0000100;
    localparam logic [6:0] CJal  = 7'b0000010;
    localparam logic [6:0] CHalt = 7'b0000001;

    // Expected strobes {dmem_rd, dmem_wr, mem_stall}
    localparam logic [2:0] ERd    = 3'b100;
    localparam logic [2:0] EWr    = 3'b010;
    localparam logic [2:0] EStall = 3'b001;

    // Expected flags {wb_regwrite, wb_halt, err_align, err_timeout}
    localparam logic [3:0] FRw   = 4'b1000;
    localparam logic [3:0] FHalt = 4'b0100;
    localparam logic [3:0] FEa   = 4'b0010;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [2:0]  rdst;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [15:0] pc;
        logic        done;
        logic [15:0] rdata;
    } in_t;

    typedef struct packed {
        logic [2:0]  strb;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  flg;
        logic [15:0] data;
        logic [2:0]  waddr;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NVec = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_result, store_data, pc_jal;
    logic        mem_read, mem_write, mem_reg, reg_write, jal, halt;
    logic [2:0]  rd_addr;
    logic [15:0] dmem_rdata;
    logic        dmem_done;
    logic [15:0] dmem_addr, dmem_wdata, wb_data;
    logic        dmem_rd, dmem_wr, mem_stall;
    logic [2:0]  wb_addr;
    logic        wb_regwrite, wb_halt, err_align, err_timeout;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NVec];

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .TIMEOUT(15)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .alu_result_syn_EXMEM     (alu_result),
        .Read_rg_data_2_syn_EXMEM (store_data),
        .PC_2_JAL_syn_EXMEM       (pc_jal),
        .MemRead_syn_EXMEM        (mem_read),
        .MemWrite_syn_EXMEM       (mem_write),
        .MemReg_syn_EXMEM         (mem_reg),
        .RegWrite_syn_EXMEM       (reg_write),
        .JAL_syn_EXMEM            (jal),
        .HALT_syn_EXMEM           (halt),
        .RegWrite_addr_syn_EXMEM  (rd_addr),
        .dmem_rdata               (dmem_rdata),
        .dmem_done                (dmem_done),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_rd                  (dmem_rd),
        .dmem_wr                  (dmem_wr),
        .mem_stall                (mem_stall),
        .wb_data                  (wb_data),
        .wb_addr                  (wb_addr),
        .wb_regwrite              (wb_regwrite),
        .wb_halt                  (wb_halt),
        .err_align                (err_align),
        .err_timeout              (err_timeout)
    );

    task automatic check(input string name, input int k, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [step %0d]: got %h, expected %h", name, k, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        {rst, mem_read, mem_write, mem_reg, reg_write, jal, halt} = v.ctl;
        rd_addr    = v.rdst;
        alu_result = v.alu;
        store_data = v.sdata;
        pc_jal     = v.pc;
        dmem_done  = v.done;
        dmem_rdata = v.rdata;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic apply(input int k, input vec_t v);
        drive(v.i);
        #3;
        check("strobes", k, {13'd0, dmem_rd, dmem_wr, mem_stall}, {13'd0, v.e.strb});
        check("dmem_addr", k, dmem_addr, v.e.addr);
        check("dmem_wdata", k, dmem_wdata, v.e.wdata);
        @(posedge clk);
        #1;
        check("wb_flags", k, {12'd0, wb_regwrite, wb_halt, err_align, err_timeout},
              {12'd0, v.e.flg});
        check("wb_data", k, wb_data, v.e.data);
        check("wb_addr", k, {13'd0, wb_addr}, {13'd0, v.e.waddr});
    endtask

    initial begin
        int  n;
        logic seen;

        // Reset
        vecs[0].i  = '{7'h00, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[0].e  = '{3'b000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 3'd0};
        // Load hit, zero latency
        vecs[1].i  = '{CRun | CRd | CMreg | CRw, 3'd3, 16'h0010, 16'h0000, 16'h0000, 1'b1,
                       16'hBEEF};
        vecs[1].e  = '{ERd, 16'h0010, 16'h0000, FRw, 16'hBEEF, 3'd3};
        // Load miss: done on the 4th request cycle
        vecs[2].i  = '{CRun | CRd | CMreg | CRw, 3'd5, 16'h0040, 16'h0000, 16'h0000, 1'b0,
                       16'h0000};
        vecs[2].e  = '{ERd | EStall, 16'h0040, 16'h0000, 4'b0000, 16'hBEEF, 3'd3};
        vecs[3]    = vecs[2];
        vecs[4]    = vecs[2];
        vecs[5].i  = '{CRun | CRd | CMreg | CRw, 3'd5, 16'h0040, 16'h0000, 16'h0000, 1'b1,
                       16'h1234};
        vecs[5].e  = '{ERd, 16'h0040, 16'h0000, FRw, 16'h1234, 3'd5};
        // Store, done after 2 cycles, RegWrite low
        vecs[6].i  = '{CRun | CWr, 3'd2, 16'h0020, 16'h00AA, 16'h0000, 1'b0, 16'h0000};
        vecs[6].e  = '{EWr | EStall, 16'h0020, 16'h00AA, 4'b0000, 16'h1234, 3'd5};
        vecs[7].i  = '{CRun | CWr, 3'd2, 16'h0020, 16'h00AA, 16'h0000, 1'b1, 16'h0000};
        vecs[7].e  = '{EWr, 16'h0020, 16'h00AA, 4'b0000, 16'h0020, 3'd2};
        // Odd-address load: dropped even with done high
        vecs[8].i  = '{CRun | CRd | CMreg | CRw, 3'd4, 16'h0011, 16'h0000, 16'h0000, 1'b1,
                       16'h5555};
        vecs[8].e  = '{3'b000, 16'h0011, 16'h0000, FEa, 16'h5555, 3'd4};
        // Plain ALU op, err_align stays set
        vecs[9].i  = '{CRun | CRw, 3'd6, 16'h7777, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[9].e  = '{3'b000, 16'h7777, 16'h0000, FRw | FEa, 16'h7777, 3'd6};
        // JAL writes the link value
        vecs[10].i = '{CRun | CRw | CJal, 3'd7, 16'h1111, 16'h0000, 16'h0202, 1'b0, 16'h0000};
        vecs[10].e = '{3'b000, 16'h1111, 16'h0000, FRw | FEa, 16'h0202, 3'd7};
        // Read and write together counts as misaligned
        vecs[11].i = '{CRun | CRd | CWr | CRw, 3'd1, 16'h0030, 16'h0000, 16'h0000, 1'b0,
                       16'h0000};
        vecs[11].e = '{3'b000, 16'h0030, 16'h0000, FEa, 16'h0030, 3'd1};
        // Reset clears err_align
        vecs[12]   = vecs[0];
        // HALT retires, then a load is ignored
        vecs[13].i = '{CRun | CHalt, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[13].e = '{3'b000, 16'h0000, 16'h0000, FHalt, 16'h0000, 3'd0};
        vecs[14].i = '{CRun | CRd | CMreg | CRw, 3'd3, 16'h0010, 16'h0000, 16'h0000, 1'b1,
                       16'h9999};
        vecs[14].e = '{3'b000, 16'h0010, 16'h0000, FHalt, 16'h0000, 3'd0};
        vecs[15]   = vecs[0];
        // Reset while BUSY drops the access
        vecs[16].i = '{CRun | CRd | CMreg | CRw, 3'd2, 16'h0060, 16'h0000, 16'h0000, 1'b0,
                       16'h0000};
        vecs[16].e = '{ERd | EStall, 16'h0060, 16'h0000, 4'b0000, 16'h0000, 3'd0};
        vecs[17].i = '{7'h00, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[17].e = '{ERd | EStall, 16'h0060, 16'h0000, 4'b0000, 16'h0000, 3'd0};
        vecs[18].i = '{CRun, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[18].e = '{3'b000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 3'd0};

        drive(vecs[0].i);
        @(posedge clk);
        #1;

        for (int k = 0; k < NVec; k++) begin
            apply(k, vecs[k]);
        end

        // Timeout: a load that never completes stalls for exactly TIMEOUT cycles.
        rst        = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        mem_reg    = 1'b1;
        reg_write  = 1'b1;
        jal        = 1'b0;
        halt       = 1'b0;
        rd_addr    = 3'd2;
        alu_result = 16'h0050;
        dmem_done  = 1'b0;
        n          = 0;
        seen       = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (!mem_stall) begin
                seen = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
        end
        check("to_released", 100, {15'd0, seen}, 16'd1);
        check("to_stall_cycles", 100, n[15:0], 16'd15);
        check("to_strobes_low", 100, {14'd0, dmem_rd, dmem_wr}, 16'd0);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_reg   = 1'b0;
        reg_write = 1'b0;
        check("to_err_set", 101, {15'd0, err_timeout}, 16'd1);
        check("to_wb_regwrite", 101, {15'd0, wb_regwrite}, 16'd0);
        #3;
        check("to_no_stall", 102, {15'd0, mem_stall}, 16'd0);
        @(posedge clk);
        #1;
        check("to_err_sticky", 102, {15'd0, err_timeout}, 16'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("to_err_reset", 103, {15'd0, err_timeout}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
